// File: rtl/dsp_mult_rr_sched_if.sv
// Bundle of requester, DSP-operand and response signals for the shared-multiplier scheduler.
// The scheduler takes the slave view; the surrounding datapath / DSP wrapper takes master.
interface dsp_mult_rr_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
);
   localparam int DATA_W = 20;
   localparam int COEF_W = 18;
   localparam int PROD_W = DATA_W + COEF_W;

   logic [NUM_REQ-1:0]        req_valid_i;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic [NUM_REQ*DATA_W-1:0] req_a_i;
   logic [NUM_REQ*COEF_W-1:0] req_b_i;
   logic [NUM_REQ-1:0]        req_unsigned_a_i;
   logic [NUM_REQ-1:0]        req_unsigned_b_i;

   logic [DATA_W-1:0]         dsp_a_o;
   logic [COEF_W-1:0]         dsp_b_o;
   logic                      dsp_unsigned_a_o;
   logic                      dsp_unsigned_b_o;
   logic [2:0]                dsp_feedback_o;
   logic [PROD_W-1:0]         dsp_z_i;

   logic                      rsp_valid_o;
   logic                      rsp_ready_i;
   logic [IDW-1:0]            rsp_id_o;
   logic [PROD_W-1:0]         rsp_z_o;

   modport slave (
      input  req_valid_i, req_a_i, req_b_i, req_unsigned_a_i, req_unsigned_b_i,
      input  dsp_z_i, rsp_ready_i,
      output req_ready_o, dsp_a_o, dsp_b_o, dsp_unsigned_a_o, dsp_unsigned_b_o,
      output dsp_feedback_o, rsp_valid_o, rsp_id_o, rsp_z_o
   );

   modport master (
      output req_valid_i, req_a_i, req_b_i, req_unsigned_a_i, req_unsigned_b_i,
      output dsp_z_i, rsp_ready_i,
      input  req_ready_o, dsp_a_o, dsp_b_o, dsp_unsigned_a_o, dsp_unsigned_b_o,
      input  dsp_feedback_o, rsp_valid_o, rsp_id_o, rsp_z_o
   );
endinterface

// File: rtl/dsp_mult_rr_sched.sv
// Round-robin sharing of one registered-input 20x18 DSP multiplier between NUM_REQ clients,
// with a tag pipe matching the DSP latency and an in-order response FIFO.
module dsp_mult_rr_sched #(
   parameter int NUM_REQ      = 4,
   parameter int MULT_LATENCY = 1,
   parameter int RSP_DEPTH    = 4,
   parameter int IDW          = $clog2(NUM_REQ)
) (
   input logic                clock_i,
   input logic                reset_n_i,
   dsp_mult_rr_sched_if.slave bus
);
   localparam int DATA_W = 20;
   localparam int COEF_W = 18;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int CW     = $clog2(RSP_DEPTH + 1);
   localparam int PW     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

   logic [IDW-1:0]    last_grant;
   logic [IDW-1:0]    win;
   logic              found;
   logic              credit;
   logic              accept;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       occupancy;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   logic [MULT_LATENCY-1:0] tag_vld_p;
   logic [IDW-1:0]          tag_id_p [MULT_LATENCY];

   logic [IDW-1:0]    fifo_id [RSP_DEPTH];
   logic [PROD_W-1:0] fifo_z  [RSP_DEPTH];

   logic [DATA_W-1:0] a_arr [NUM_REQ];
   logic [COEF_W-1:0] b_arr [NUM_REQ];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign a_arr[g] = bus.req_a_i[g*DATA_W +: DATA_W];
      assign b_arr[g] = bus.req_b_i[g*COEF_W +: COEF_W];
   end

   // Credit counts only registered state, so a pop this cycle frees a slot next cycle.
   assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
   assign credit    = occupancy < (CW+1)'(RSP_DEPTH);

   always_comb begin
      logic [IDW-1:0] k;
      int             s;
      win   = last_grant;
      found = 1'b0;
      k     = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         s = int'(last_grant) + i;
         if (s >= NUM_REQ) s = s - NUM_REQ;
         k = IDW'(s);
         if (!found && bus.req_valid_i[k]) begin
            win   = k;
            found = 1'b1;
         end
      end
   end

   assign accept = found && credit && reset_n_i;

   always_comb begin
      bus.req_ready_o = '0;
      if (accept) bus.req_ready_o[win] = 1'b1;
   end

   always_comb begin
      bus.dsp_a_o          = '0;
      bus.dsp_b_o          = '0;
      bus.dsp_unsigned_a_o = 1'b0;
      bus.dsp_unsigned_b_o = 1'b0;
      if (accept) begin
         bus.dsp_a_o          = a_arr[win];
         bus.dsp_b_o          = b_arr[win];
         bus.dsp_unsigned_a_o = bus.req_unsigned_a_i[win];
         bus.dsp_unsigned_b_o = bus.req_unsigned_b_i[win];
      end
   end

   assign bus.dsp_feedback_o = 3'b000;

   assign push      = tag_vld_p[MULT_LATENCY-1];
   assign fifo_full = (fifo_count == CW'(RSP_DEPTH));
   assign pop       = bus.rsp_valid_o && bus.rsp_ready_i;

   // Stage p0..pN: tag travels alongside the DSP product; captured into the FIFO at pipe exit.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         last_grant <= LAST_IDX;
         inflight   <= '0;
         tag_vld_p  <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (accept) last_grant <= win;
         inflight     <= inflight + CW'(accept) - CW'(push);
         tag_vld_p[0] <= accept;
         for (int i = 1; i < MULT_LATENCY; i++) tag_vld_p[i] <= tag_vld_p[i-1];
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clock_i) begin
      tag_id_p[0] <= win;
      for (int i = 1; i < MULT_LATENCY; i++) tag_id_p[i] <= tag_id_p[i-1];
      if (push) begin
         fifo_id[wr_ptr] <= tag_id_p[MULT_LATENCY-1];
         fifo_z[wr_ptr]  <= bus.dsp_z_i;
      end
   end

   // Head entry is only meaningful when non-empty; storage itself is never reset.
   assign bus.rsp_valid_o = (fifo_count != '0);
   assign bus.rsp_id_o    = bus.rsp_valid_o ? fifo_id[rd_ptr] : '0;
   assign bus.rsp_z_o     = bus.rsp_valid_o ? fifo_z[rd_ptr]  : '0;

   a_no_overflow : assert property (@(posedge clock_i) disable iff (!reset_n_i)
      !(push && !pop && fifo_full));
endmodule

// File: tb/tb_dsp_mult_rr_sched.sv
// Bench for dsp_mult_rr_sched: behavioural DSP stand-in, queue-based response model checked
// every cycle, plus literal expectations for the directed cases.
module tb_dsp_mult_rr_sched;
   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int IDW   = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   dsp_mult_rr_sched_if #(.NUM_REQ(N), .IDW(IDW)) bus ();

   dsp_mult_rr_sched #(
      .NUM_REQ(N), .MULT_LATENCY(1), .RSP_DEPTH(DEPTH), .IDW(IDW)
   ) dut (
      .clock_i(clk),
      .reset_n_i(reset_n),
      .bus(bus)
   );

   // DSP stand-in: registered inputs, product available the cycle after capture.
   logic [19:0]        dsp_a_r;
   logic [17:0]        dsp_b_r;
   logic               dsp_ua_r, dsp_ub_r;
   logic signed [20:0] dsp_a_ext;
   logic signed [18:0] dsp_b_ext;
   logic signed [39:0] dsp_prod;
   always_ff @(posedge clk) begin
      dsp_a_r  <= bus.dsp_a_o;
      dsp_b_r  <= bus.dsp_b_o;
      dsp_ua_r <= bus.dsp_unsigned_a_o;
      dsp_ub_r <= bus.dsp_unsigned_b_o;
   end
   assign dsp_a_ext   = {dsp_ua_r ? 1'b0 : dsp_a_r[19], dsp_a_r};
   assign dsp_b_ext   = {dsp_ub_r ? 1'b0 : dsp_b_r[17], dsp_b_r};
   assign dsp_prod    = 40'(dsp_a_ext) * 40'(dsp_b_ext);
   assign bus.dsp_z_i = dsp_prod[37:0];

   function automatic logic [37:0] ref_mul(input logic [19:0] a, input logic [17:0] b,
                                           input logic ua, input logic ub);
      longint av, bv;
      av = ua ? longint'(a) : longint'($signed(a));
      bv = ub ? longint'(b) : longint'($signed(b));
      return 38'(av * bv);
   endfunction

   typedef struct { int id; logic [37:0] z; int due; } exp_t;
   typedef struct { int id; logic [37:0] z; } lit_t;
   exp_t mq[$];
   lit_t lq[$];

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   lg = N - 1;
   int   phase = 0;
   int   last_phase = 0;
   int   phase_acc = 0;
   logic bp_probe = 1'b0;
   logic end_probe = 1'b0;
   logic end_done = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model and per-cycle compare, sampled on the falling edge.
   int          win_m, kk;
   logic [N-1:0] exp_rdy;
   logic        exp_vld;
   logic [42:0] exp_dsp;
   logic [19:0] ma;
   logic [17:0] mb;
   logic        mua, mub;
   initial forever begin
      @(negedge clk);
      if (phase != last_phase) begin
         phase_acc  = 0;
         last_phase = phase;
      end
      if (!reset_n) begin
         chk("reset_req_ready", 64'(bus.req_ready_o), 64'd0);
         chk("reset_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
         chk("reset_rsp_id", 64'(bus.rsp_id_o), 64'd0);
         chk("reset_rsp_z", 64'(bus.rsp_z_o), 64'd0);
         mq.delete();
         lg = N - 1;
      end else begin
         win_m = -1;
         if (mq.size() < DEPTH) begin
            for (int i = 1; i <= N; i++) begin
               kk = (lg + i) % N;
               if (win_m < 0 && bus.req_valid_i[kk]) win_m = kk;
            end
         end
         exp_rdy = '0;
         exp_dsp = '0;
         ma = '0; mb = '0; mua = 1'b0; mub = 1'b0;
         if (win_m >= 0) begin
            exp_rdy[win_m] = 1'b1;
            ma  = bus.req_a_i[win_m*20 +: 20];
            mb  = bus.req_b_i[win_m*18 +: 18];
            mua = bus.req_unsigned_a_i[win_m];
            mub = bus.req_unsigned_b_i[win_m];
            exp_dsp = {ma, mb, mua, mub, 3'b000};
         end
         chk("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
         chk("dsp_drive", 64'({bus.dsp_a_o, bus.dsp_b_o, bus.dsp_unsigned_a_o,
                               bus.dsp_unsigned_b_o, bus.dsp_feedback_o}), 64'(exp_dsp));
         exp_vld = (mq.size() > 0) && (mq[0].due <= cyc);
         chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(exp_vld));
         chk("rsp_id", 64'(bus.rsp_id_o), exp_vld ? 64'(mq[0].id) : 64'd0);
         chk("rsp_z", 64'(bus.rsp_z_o), exp_vld ? 64'(mq[0].z) : 64'd0);
         if (exp_vld && bus.rsp_ready_i) begin
            if (lq.size() > 0) begin
               chk("literal_id", 64'(bus.rsp_id_o), 64'(lq[0].id));
               chk("literal_z", 64'(bus.rsp_z_o), 64'(lq[0].z));
               void'(lq.pop_front());
            end
            void'(mq.pop_front());
         end
         if (win_m >= 0) begin
            mq.push_back('{win_m, ref_mul(ma, mb, mua, mub), cyc + 2});
            lg = win_m;
            phase_acc++;
         end
         if (bp_probe) begin
            chk("bp_accept_count", 64'(phase_acc), 64'd4);
            chk("bp_ready_low", 64'(bus.req_ready_o), 64'd0);
         end
         if (end_probe && !end_done) begin
            chk("model_drained", 64'(mq.size()), 64'd0);
            chk("literals_consumed", 64'(lq.size()), 64'd0);
            end_done = 1'b1;
         end
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [19:0] a, input logic [17:0] b,
                          input logic ua, input logic ub);
      bus.req_a_i[k*20 +: 20]    = a;
      bus.req_b_i[k*18 +: 18]    = b;
      bus.req_unsigned_a_i[k]    = ua;
      bus.req_unsigned_b_i[k]    = ub;
   endtask

   task automatic rand_ops();
      for (int k = 0; k < N; k++)
         set_req(k, 20'($urandom), 18'($urandom), 1'($urandom), 1'($urandom));
   endtask

   initial begin
      bus.req_valid_i      = '0;
      bus.req_a_i          = '0;
      bus.req_b_i          = '0;
      bus.req_unsigned_a_i = '0;
      bus.req_unsigned_b_i = '0;
      bus.rsp_ready_i      = 1'b1;
      reset_n              = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      step();

      // Single signed request: 3 * -5.
      phase = 1;
      lq.push_back('{0, 38'h3F_FFFF_FFF1});
      set_req(0, 20'd3, 18'h3FFFB, 1'b0, 1'b0);
      bus.req_valid_i = 4'b0001;
      step();
      bus.req_valid_i = '0;
      repeat (5) step();

      // Unsigned corner: 0xFFFFF * 2.
      phase = 2;
      lq.push_back('{2, 38'h00_001F_FFFE});
      set_req(2, 20'hFFFFF, 18'd2, 1'b1, 1'b1);
      bus.req_valid_i = 4'b0100;
      step();
      bus.req_valid_i = '0;
      repeat (5) step();

      // Round robin, all requesters valid, responses always accepted.
      phase = 3;
      bus.req_valid_i = 4'b1111;
      for (int c = 0; c < 24; c++) begin
         rand_ops();
         step();
      end
      bus.req_valid_i = '0;
      repeat (5) step();

      // Backpressure: only DEPTH accepts while responses are stalled.
      phase = 4;
      rand_ops();
      bus.rsp_ready_i = 1'b0;
      bus.req_valid_i = 4'b1111;
      repeat (8) step();
      bp_probe = 1'b1;
      step();
      bp_probe = 1'b0;
      bus.rsp_ready_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
         rand_ops();
         step();
      end
      bus.req_valid_i = '0;
      repeat (6) step();

      // Full FIFO then pop every cycle, then irregular response acceptance.
      phase = 5;
      bus.rsp_ready_i = 1'b0;
      bus.req_valid_i = 4'b1111;
      repeat (6) step();
      bus.rsp_ready_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         rand_ops();
         step();
      end
      for (int c = 0; c < 20; c++) begin
         rand_ops();
         bus.rsp_ready_i = 1'($urandom);
         step();
      end
      bus.req_valid_i = '0;
      bus.rsp_ready_i = 1'b1;
      repeat (8) step();

      // Reset with 3 buffered and 1 in flight; first response afterwards is req1 7*6.
      phase = 6;
      rand_ops();
      bus.rsp_ready_i = 1'b0;
      bus.req_valid_i = 4'b1111;
      repeat (4) step();
      bus.req_valid_i = '0;
      reset_n = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
      bus.rsp_ready_i = 1'b1;
      lq.push_back('{1, 38'd42});
      set_req(1, 20'd7, 18'd6, 1'b0, 1'b0);
      bus.req_valid_i = 4'b0010;
      step();
      bus.req_valid_i = '0;
      repeat (5) step();

      end_probe = 1'b1;
      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
